// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU, with a single registered response slot.
// Latency: 1 cycle from accept (reqN_valid & reqN_ready) to rsp_valid. Sustains one op per cycle.
// Backpressure: a full slot with rsp_ready low forces both reqN_ready low. Inputs are never stored.
//
// Ports:
//   clk, rst_n                          clock and asynchronous active-low reset
//   reqN_valid/ready/da/db/aluctr       requester N handshake and operation (N = 0, 1)
//   alu_da/alu_db/alu_aluctr            operation driven to the shared ALU
//   alu_result/alu_zero                 combinational result returned by the shared ALU
//   rsp_valid/ready/id/result/zero      registered response slot
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every contention.
// If it is left undefined, contention alternates round-robin starting with requester 0.

module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_da,
    input  logic [31:0] req0_db,
    input  logic [3:0]  req0_aluctr,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_da,
    input  logic [31:0] req1_db,
    input  logic [3:0]  req1_aluctr,
    output logic [31:0] alu_da,
    output logic [31:0] alu_db,
    output logic [3:0]  alu_aluctr,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_id_q, rsp_id_d;

    logic        can_issue;
    logic        grant_vld;
    logic        grant_id;
    logic        mux_sel;

    assign rsp_valid  = (state_q == FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

    // rst_n is folded in so that no handshake can complete while reset is held,
    // even though the slot already reads EMPTY at that point.
    assign can_issue = rst_n & ((state_q == EMPTY) | (rsp_valid & rsp_ready));

    // Arbitration
    always_comb begin
        grant_vld = can_issue & (req0_valid | req1_valid);
        grant_id  = 1'b0;
        if (req0_valid & req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_grant_q;
`endif
        end else begin
            grant_id = req1_valid;
        end
    end

    assign req0_ready = grant_vld & ~grant_id;
    assign req1_ready = grant_vld &  grant_id;

    // When nobody is granted, the ALU still sees a real requester's fields
    // (the last winner), so its inputs are never X.
    assign mux_sel    = grant_vld ? grant_id : last_grant_q;
    assign alu_da     = mux_sel ? req1_da     : req0_da;
    assign alu_db     = mux_sel ? req1_db     : req0_db;
    assign alu_aluctr = mux_sel ? req1_aluctr : req0_aluctr;

    // Response slot next state
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;
        if (grant_vld) begin
            // This covers both an empty slot and a full slot that is drained in
            // the same cycle.
            state_d      = FULL;
            last_grant_d = grant_id;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_id_d     = grant_id;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU, a transaction-level reference model
// checked every cycle, and directed scenarios with literal expected values.
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_da = '0, req0_db = '0, req1_da = '0, req1_db = '0;
    logic [3:0]  req0_aluctr = '0, req1_aluctr = '0;
    logic [31:0] alu_da, alu_db, alu_result;
    logic [3:0]  alu_aluctr;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero;
    logic [31:0] rsp_result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_da(req0_da),
        .req0_db(req0_db), .req0_aluctr(req0_aluctr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_da(req1_da),
        .req1_db(req1_db), .req1_aluctr(req1_aluctr),
        .alu_da(alu_da), .alu_db(alu_db), .alu_aluctr(alu_aluctr),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    // Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass da.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_aluctr, alu_da, alu_db);
    assign alu_zero   = (alu_result == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the response slot is a queue of at most one entry.
    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
    } rsp_t;

    rsp_t rsp_q[$];
    int   m_last = 1;
    int   grant_log[$];

    always begin : compare
        int   win;
        int   sel;
        bit   pop;
        rsp_t nxt;
        @(negedge clk);
        chk("rsp_valid", rsp_valid, rsp_q.size() != 0);
        if (rsp_q.size() != 0) begin
            chk("rsp_id", rsp_id, rsp_q[0].id);
            chk("rsp_result", rsp_result, rsp_q[0].res);
            chk("rsp_zero", rsp_zero, rsp_q[0].zero);
        end
        win = -1;
        if (rst_n && (rsp_q.size() == 0 || rsp_ready)) begin
            if (req0_valid && req1_valid) win = FIXED ? 0 : 1 - m_last;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        chk("req0_ready", req0_ready, win == 0);
        chk("req1_ready", req1_ready, win == 1);
        sel = (win >= 0) ? win : m_last;
        chk("alu_da", alu_da, sel == 1 ? req1_da : req0_da);
        chk("alu_db", alu_db, sel == 1 ? req1_db : req0_db);
        chk("alu_aluctr", {28'd0, alu_aluctr}, {28'd0, sel == 1 ? req1_aluctr : req0_aluctr});
        pop = (rsp_q.size() != 0) && rsp_ready;
        if (win == 1) nxt.res = alu_fn(req1_aluctr, req1_da, req1_db);
        else          nxt.res = alu_fn(req0_aluctr, req0_da, req0_db);
        nxt.id   = win;
        nxt.zero = (nxt.res == 32'd0);
        @(posedge clk);
        if (!rst_n) begin
            rsp_q.delete();
            m_last = 1;
        end else begin
            if (pop) void'(rsp_q.pop_front());
            if (win >= 0) begin
                rsp_q.push_back(nxt);
                m_last = win;
                grant_log.push_back(win);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq[4];
        bit acc0, acc1;
        if (FIXED) seq = '{0, 0, 0, 0};
        else       seq = '{0, 1, 0, 1};

        // Reset values
        @(negedge clk);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_result", rsp_result, 32'd0);
        chk("reset rsp_zero", rsp_zero, 1'b0);
        chk("reset rsp_id", rsp_id, 1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("reset readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        rst_n = 1'b1;

        // Single op: 5 + 7 on requester 0
        req0_valid = 1'b1; req0_aluctr = 4'h0; req0_da = 32'd5; req0_db = 32'd7;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("single req0_ready", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_aluctr = 4'h1; req1_da = 32'd9; req1_db = 32'd9;

        // Backpressure for 3 cycles while the slot holds 12
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp rsp_valid", rsp_valid, 1'b1);
            chk("bp rsp_result", rsp_result, 32'd12);
            chk("bp rsp_id", rsp_id, 1'b0);
            chk("bp rsp_zero", rsp_zero, 1'b0);
            chk("bp readies", {30'd0, req1_ready, req0_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release req1_ready", req1_ready, 1'b1);
        step();
        req1_valid = 1'b0;

        // Zero flag from 9 - 9
        @(negedge clk);
        chk("zero rsp_result", rsp_result, 32'd0);
        chk("zero rsp_zero", rsp_zero, 1'b1);
        chk("zero rsp_id", rsp_id, 1'b1);
        step();

        // Reset while FULL
        req0_valid = 1'b1; req0_aluctr = 4'h0; req0_da = 32'd1; req0_db = 32'd2;
        rsp_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("midop full", rsp_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk("midop async rsp_valid", rsp_valid, 1'b0);
        chk("midop req0_ready", req0_ready, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        req0_valid = 1'b0;

        // Contention right after reset: requester 0 wins first
        grant_log.delete();
        req0_valid = 1'b1; req0_aluctr = 4'h2; req0_da = 32'hF0F0; req0_db = 32'h0FF0;
        req1_valid = 1'b1; req1_aluctr = 4'h3; req1_da = 32'h1000; req1_db = 32'h0001;
        rsp_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) chk($sformatf("contention grant %0d", i), req1_ready, seq[i]);
            if (i > 0) chk($sformatf("contention rsp_id %0d", i - 1), rsp_id, seq[i - 1]);
            if (i == 3) begin
                step();
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        chk("contention grant count", grant_log.size(), 4);
        step();

        // Mixed traffic: requesters hold payload until accepted
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid || acc0) begin
                req0_valid  = ($urandom_range(0, 2) != 0);
                req0_aluctr = 4'($urandom_range(0, 5));
                req0_da     = $urandom_range(0, 20);
                req0_db     = $urandom_range(0, 20);
            end
            if (!req1_valid || acc1) begin
                req1_valid  = ($urandom_range(0, 2) != 0);
                req1_aluctr = 4'($urandom_range(0, 5));
                req1_da     = $urandom;
                req1_db     = $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
